// File: rtl/prog_loader.sv
// UART boot loader: receives A5 N <4N bytes> [csum] frames, writes words to program RAM, releases core.
// Latency: RAM strobe one cycle after the 4th byte of each word; done_o rises with the last strobe.
// No backpressure: the serial link is free-running; optional checksum byte enabled by LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 32
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        core_rst_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    MAX_N     = 8'(MAX_WORDS);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE, S_ERR
    } state_t;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_byte;
    logic          byte_vld, frame_err;
    logic          half_tick, bit_tick;

    state_t        state, state_next;
    logic [7:0]    len, index;
    logic [1:0]    byte_cnt;
    logic [23:0]   word;
    logic          last_byte, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign half_tick = (rx_cnt == HALF_LAST);
    assign bit_tick  = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Counter restarts at the start midpoint so later samples land mid-bit.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || (rx_state == RX_START && half_tick) || bit_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_state == RX_START)
                rx_bit <= '0;
            else if (rx_state == RX_DATA && bit_tick)
                rx_bit <= rx_bit + 3'd1;
            if (rx_state == RX_DATA && bit_tick)
                rx_byte <= {rx_sync, rx_byte[7:1]};
            byte_vld  <= (rx_state == RX_STOP) && bit_tick && rx_sync;
            frame_err <= (rx_state == RX_STOP) && bit_tick && !rx_sync;
        end
    end

    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = (index == len - 8'd1);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (frame_err && state != S_DONE) begin
            state_next = S_ERR;
        end else if (byte_vld) begin
            case (state)
                S_IDLE: if (rx_byte == SYNC_BYTE) state_next = S_LEN;
                S_LEN:  state_next = (rx_byte != 8'd0 && rx_byte <= MAX_N) ? S_DATA : S_ERR;
`ifdef LOADER_CHECKSUM_EN
                S_DATA: if (last_byte && last_word) state_next = S_CSUM;
                S_CSUM: state_next = (rx_byte == csum) ? S_DONE : S_ERR;
`else
                S_DATA: if (last_byte && last_word) state_next = S_DONE;
`endif
                S_ERR:  if (rx_byte == SYNC_BYTE) state_next = S_LEN;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        core_rst_o = 1'b1;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state)
            S_DONE: begin
                core_rst_o = 1'b0;
                done_o     = 1'b1;
            end
            S_ERR:   err_o = 1'b1;
            default: core_rst_o = 1'b1;
        endcase
    end

    // Address/data are only updated on a strobe, so they hold between writes.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            len        <= '0;
            index      <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            ram_en_o   <= 1'b0;
            ram_we_o   <= 4'h0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            ram_en_o <= 1'b0;
            ram_we_o <= 4'h0;
            if (byte_vld && state == S_LEN) begin
                len      <= rx_byte;
                index    <= '0;
                byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (byte_vld && state == S_DATA) begin
                word     <= {rx_byte, word[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_byte;
`endif
                if (last_byte) begin
                    ram_en_o   <= 1'b1;
                    ram_we_o   <= 4'hF;
                    ram_addr_o <= {22'd0, index, 2'b00};
                    ram_data_o <= {rx_byte, word};
                    index      <= index + 8'd1;
                end
            end
        end
    end
endmodule
